// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor step per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [5:0]       cnt;
    logic             br, a_msb, b_msb;
    logic             a0, b0, d, br_next;
    logic [WIDTH-1:0] diff_full;

    assign a0        = a_sh[0];
    assign b0        = b_sh[0];
    assign d         = a0 ^ b0 ^ br;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br);
    // Result as it will look once the current (final) bit lands in the MSB
    assign diff_full = {d, res[WIDTH-1:1]};
    assign in_ready  = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = SHIFT;
            SHIFT:   if (cnt == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    res  <= diff_full;
                    br   <= br_next;
                    cnt  <= cnt + 6'd1;
                    // Flags are registered on the final step so they stay frozen through DONE
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        diff      <= diff_full;
                        borrow    <= br_next;
                        ovf       <= (a_msb != b_msb) && (d != a_msb);
                        zero      <= ~|diff_full;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic
// reference model, plus directed latency, backpressure and mid-operation reset cases.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow, ovf, zero;

    int testsRun  = 0;
    int failCount = 0;
    int hsCount   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Result handshake counter, used to detect lost or duplicated operations
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hsCount = hsCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer subtraction, unsigned compare and signed range check
    task automatic refModel(input logic [7:0] x, input logic [7:0] y,
                            output logic [7:0] eDiff, output logic eBorrow,
                            output logic eOvf, output logic eZero);
        int sx, sy, sd, ud;
        ud      = int'(x) - int'(y);
        eDiff   = 8'(ud & 255);
        eBorrow = (int'(x) < int'(y));
        sx      = (x > 127) ? int'(x) - 256 : int'(x);
        sy      = (y > 127) ? int'(y) - 256 : int'(y);
        sd      = sx - sy;
        eOvf    = (sd > 127) || (sd < -128);
        eZero   = (eDiff == 8'd0);
    endtask

    task automatic waitReady(input string tag);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One complete operation: accept, measure latency, check result, stall, release
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                                 input int stall, input string tag);
        logic [7:0] eDiff;
        logic       eBorrow, eOvf, eZero;
        int         lat;
        refModel(opA, opB, eDiff, eBorrow, eOvf, eZero);
        waitReady(tag);
        in_valid  = 1'b1;
        a         = opA;
        b         = opB;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        checkOutput({tag, "_diff"},   32'(diff),   32'(eDiff));
        checkOutput({tag, "_borrow"}, 32'(borrow), 32'(eBorrow));
        checkOutput({tag, "_ovf"},    32'(ovf),    32'(eOvf));
        checkOutput({tag, "_zero"},   32'(zero),   32'(eZero));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = 8'h11;
            b        = 8'($urandom);
            @(negedge clk);
            checkOutput({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_stall_ready"}, 32'(in_ready),  32'd0);
            checkOutput({tag, "_stall_diff"},  32'(diff),      32'(eDiff));
            checkOutput({tag, "_stall_flags"}, 32'({borrow, ovf, zero}),
                        32'({eBorrow, eOvf, eZero}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_release_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int hsStart;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_outputs",   32'({diff, borrow, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'd100, 8'd37,  0, "t1_100m37");
        applyStimulus(8'h05,  8'h0A,  0, "t2_05m0A");
        applyStimulus(8'h80,  8'h01,  0, "t2_80m01");
        applyStimulus(8'h7F,  8'hFF,  0, "t3_7FmFF");
        applyStimulus(8'h5A,  8'h5A,  0, "t3_equal");
        applyStimulus(8'hC3,  8'h21,  5, "t4_backpressure");

        // Mid-operation asynchronous reset during the third shift cycle
        waitReady("t5");
        in_valid = 1'b1;
        a        = 8'h33;
        b        = 8'h11;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("t5_reset_diff",      32'(diff),      32'd0);
        checkOutput("t5_reset_flags",     32'({borrow, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'd9, 8'd3, 0, "t5_after_reset");

        hsStart = hsCount;
        for (int n = 0; n < 50; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "t6_rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        checkOutput("t6_handshakes", 32'(hsCount - hsStart), 32'd50);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
